// File: rtl/noc_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// NocMemReqArbiter (module noc_mem_req_arbiter)
//
// Purpose:
//   Packet-atomic round-robin arbiter. It merges two NoC2 request streams into
//   the single memory-side request stream that feeds the AXI4 bridge.
//   The arbiter works in cut-through mode and adds no latency. The header flit
//   passes in the same cycle it is granted. Flits of different packets are
//   never interleaved.
//
// Ports:
//   clk            memory-controller clock
//   rst_n          asynchronous active-low reset
//   in0_val/dat    requester 0 flit valid / data
//   in0_rdy        requester 0 flit accepted
//   in1_val/dat    requester 1 flit valid / data
//   in1_rdy        requester 1 flit accepted
//   out_val/dat    merged flit valid / data
//   out_rdy        downstream ready
//   busy           a packet is in flight (FWD state)
//   gnt_id         input currently granted, or last granted
//   pkt_cnt0/1     headers accepted per input (only with NOC_MEM_ARB_PERF_EN)
//
// Configuration:
//   NOC_MEM_ARB_PERF_EN  when defined, adds the per-input header counters.
// ----------------------------------------------------------------------------
module noc_mem_req_arbiter #(
    parameter int DATA_W = 64,
    parameter int LEN_LO = 22,
    parameter int LEN_W  = 8
`ifdef NOC_MEM_ARB_PERF_EN
   ,parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_val,
    input  logic [DATA_W-1:0] in0_dat,
    output logic              in0_rdy,
    input  logic              in1_val,
    input  logic [DATA_W-1:0] in1_dat,
    output logic              in1_rdy,
    output logic              out_val,
    output logic [DATA_W-1:0] out_dat,
    input  logic              out_rdy,
    output logic              busy,
    output logic              gnt_id
`ifdef NOC_MEM_ARB_PERF_EN
   ,output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

    typedef enum logic {IDLE, FWD} state_t;

    state_t             state;
    logic               rr_ptr;
    logic [LEN_W-1:0]   remain;
    logic               sel;
    logic               hs;
    logic [LEN_W-1:0]   hdr_len;

    // Selects the input that drives the output this cycle. While a packet
    // is in flight, the selection stays locked to the granted input. In IDLE,
    // the round-robin pointer has priority. If the preferred input is not
    // valid, the other input is used when it is valid. With no valid input,
    // the selection stays on the preferred input.
    always_comb begin
        sel = rr_ptr;
        if (state == FWD) begin
            sel = gnt_id;
        end else if (rr_ptr ? in1_val : in0_val) begin
            sel = rr_ptr;
        end else if (rr_ptr ? in0_val : in1_val) begin
            sel = ~rr_ptr;
        end
    end

    // Data path mux and handshake. The valid and ready signals are gated by
    // rst_n. This keeps the output silent while reset is held, and the gating
    // takes effect asynchronously.
    assign out_dat = sel ? in1_dat : in0_dat;
    assign out_val = rst_n & (sel ? in1_val : in0_val);
    assign in0_rdy = rst_n & out_rdy & ~sel;
    assign in1_rdy = rst_n & out_rdy & sel;
    assign hs      = out_val & out_rdy;
    assign hdr_len = out_dat[LEN_LO +: LEN_W];
    assign busy    = (state == FWD);

    // Packet-level state machine.
    // In IDLE, a header handshake records the grant and hands priority to the
    // other input. A zero-length header is a single-flit packet, so the FSM
    // stays in IDLE and arbitrates again on the next cycle.
    // In FWD, each handshake counts one payload flit. The last payload flit
    // returns the FSM to IDLE.
    // The FWD check of remain != 0 keeps the counter from underflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            remain <= '0;
            gnt_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        gnt_id <= sel;
                        rr_ptr <= ~sel;
                        if (hdr_len != '0) begin
                            remain <= hdr_len;
                            state  <= FWD;
                        end
                    end
                end
                FWD: begin
                    if (hs && remain != '0) begin
                        remain <= remain - 1'b1;
                        if (remain == LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOC_MEM_ARB_PERF_EN
    // Per-input header counters. Each counter counts header handshakes from
    // its input and wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (state == IDLE && hs) begin
            if (sel) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for noc_mem_req_arbiter.
//
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// at the following falling edge. Each checked row therefore describes one
// clock cycle. The handshake in a row takes effect at the next rising edge.
// ----------------------------------------------------------------------------
module tb_noc_mem_req_arbiter;

    localparam int DATA_W = 64;
    localparam int LEN_LO = 22;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              in0_val;
    logic [DATA_W-1:0] in0_dat;
    logic              in0_rdy;
    logic              in1_val;
    logic [DATA_W-1:0] in1_dat;
    logic              in1_rdy;
    logic              out_val;
    logic [DATA_W-1:0] out_dat;
    logic              out_rdy;
    logic              busy;
    logic              gnt_id;
`ifdef NOC_MEM_ARB_PERF_EN
    logic [31:0]       pkt_cnt0;
    logic [31:0]       pkt_cnt1;
`endif

    int total;
    int bad;

    noc_mem_req_arbiter #(
        .DATA_W(DATA_W),
        .LEN_LO(LEN_LO),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in0_val (in0_val),
        .in0_dat (in0_dat),
        .in0_rdy (in0_rdy),
        .in1_val (in1_val),
        .in1_dat (in1_dat),
        .in1_rdy (in1_rdy),
        .out_val (out_val),
        .out_dat (out_dat),
        .out_rdy (out_rdy),
        .busy    (busy),
        .gnt_id  (gnt_id)
`ifdef NOC_MEM_ARB_PERF_EN
       ,.pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
`endif
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Time limit so that the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        bit                rst;
        logic              v0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [DATA_W-1:0] d1;
        logic              rdy;
        logic              e_val;
        logic [DATA_W-1:0] e_dat;
        logic              e_r0;
        logic              e_r1;
        logic              e_busy;
        logic              e_gnt;
    } vec_t;

    vec_t tbl[$];

    // Builds a header flit that carries the given length and a small tag.
    function automatic logic [DATA_W-1:0] hdr(input int len, input int tag);
        logic [DATA_W-1:0] h;
        h = DATA_W'(tag);
        h[LEN_LO +: LEN_W] = LEN_W'(len);
        return h;
    endfunction

    function automatic vec_t mk(input bit rst, input logic v0, input logic [DATA_W-1:0] d0,
                                input logic v1, input logic [DATA_W-1:0] d1, input logic rdy,
                                input logic ev, input logic [DATA_W-1:0] ed, input logic er0,
                                input logic er1, input logic eb, input logic eg);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
        v.e_val = ev; v.e_dat = ed; v.e_r0 = er0; v.e_r1 = er1; v.e_busy = eb; v.e_gnt = eg;
        return v;
    endfunction

    // Compares one value and records the result.
    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: act=%h req=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for a rising edge and then drives a new cycle of inputs.
    task automatic applyStimulus(input logic v0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [DATA_W-1:0] d1,
                                 input logic rdy);
        @(posedge clk);
        #1;
        in0_val = v0; in0_dat = d0;
        in1_val = v1; in1_dat = d1;
        out_rdy = rdy;
    endtask

    // Pulses reset between clock edges while all inputs are quiet.
    task automatic doReset();
        @(posedge clk);
        #1;
        in0_val = 1'b0; in0_dat = '0;
        in1_val = 1'b0; in1_dat = '0;
        out_rdy = 1'b0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    initial begin
        int p;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        in0_val = 1'b0; in0_dat = '0;
        in1_val = 1'b0; in1_dat = '0;
        out_rdy = 1'b0;

        // Table columns: rst, v0, d0, v1, d1, rdy | exp val, dat, r0, r1, busy, gnt
        // Single 3-flit packet on in0.
        tbl.push_back(mk(1, 1, hdr(2,'h10), 0, 0, 1,  1, hdr(2,'h10), 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h11,        0, 0, 1,  1, 'h11,        1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h12,        0, 0, 1,  1, 'h12,        1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,           0, 0, 1,  0, 0,           0, 1, 0, 0));
        // Both inputs valid from reset, len=1 packets, strict alternation.
        tbl.push_back(mk(1, 1, hdr(1,'h20), 1, hdr(1,'h30), 1,  1, hdr(1,'h20), 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h21,        1, hdr(1,'h30), 1,  1, 'h21,        1, 0, 1, 0));
        tbl.push_back(mk(0, 1, hdr(1,'h22), 1, hdr(1,'h30), 1,  1, hdr(1,'h30), 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, hdr(1,'h22), 1, 'h31,        1,  1, 'h31,        0, 1, 1, 1));
        tbl.push_back(mk(0, 1, hdr(1,'h22), 1, hdr(1,'h32), 1,  1, hdr(1,'h22), 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h23,        1, hdr(1,'h32), 1,  1, 'h23,        1, 0, 1, 0));
        // Back-to-back len=0 headers, then header selection under back-pressure.
        tbl.push_back(mk(1, 1, 'h40, 1, 'h50, 1,  1, 'h40, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h41, 1, 'h50, 1,  1, 'h50, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h41, 1, 'h51, 1,  1, 'h41, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h42, 1, 'h51, 1,  1, 'h51, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h42, 1, 'h52, 0,  1, 'h42, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h42, 1, 'h52, 0,  1, 'h52, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            if (tbl[i].rst) doReset();
            applyStimulus(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
            @(negedge clk);
            checkOutput($sformatf("row%0d out_val", i), DATA_W'(out_val), DATA_W'(tbl[i].e_val));
            checkOutput($sformatf("row%0d out_dat", i), out_dat, tbl[i].e_dat);
            checkOutput($sformatf("row%0d in0_rdy", i), DATA_W'(in0_rdy), DATA_W'(tbl[i].e_r0));
            checkOutput($sformatf("row%0d in1_rdy", i), DATA_W'(in1_rdy), DATA_W'(tbl[i].e_r1));
            checkOutput($sformatf("row%0d busy", i),    DATA_W'(busy),    DATA_W'(tbl[i].e_busy));
            checkOutput($sformatf("row%0d gnt_id", i),  DATA_W'(gnt_id),  DATA_W'(tbl[i].e_gnt));
        end

        // A 4-flit packet on in0 must stay contiguous while in1 raises valid
        // in the middle of the packet.
        doReset();
        for (int c = 0; c < 5; c++) begin
            logic [DATA_W-1:0] f0;
            f0 = (c == 0) ? hdr(3, 'h60) : DATA_W'('h60 + c);
            applyStimulus(c < 4, f0, c >= 1, hdr(2, 'h70), 1'b1);
            @(negedge clk);
            checkOutput($sformatf("lock c%0d out_dat", c), out_dat, (c < 4) ? f0 : hdr(2, 'h70));
            checkOutput($sformatf("lock c%0d in1_rdy", c), DATA_W'(in1_rdy), DATA_W'(c == 4));
            checkOutput($sformatf("lock c%0d busy", c), DATA_W'(busy), DATA_W'(c >= 1 && c <= 3));
        end

        // Toggling back-pressure during a len=4 packet. The FWD phase takes
        // 8 cycles, and out_dat must hold its value while the output is stalled.
        doReset();
        applyStimulus(1'b1, hdr(4, 'h80), 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("bp hdr out_dat", out_dat, hdr(4, 'h80));
        p = 0;
        for (int k = 0; k < 8; k++) begin
            logic r;
            r = (k % 2) == 1;
            applyStimulus(1'b1, DATA_W'('h81 + p), 1'b0, '0, r);
            @(negedge clk);
            checkOutput($sformatf("bp k%0d out_dat", k), out_dat, DATA_W'('h81 + p));
            checkOutput($sformatf("bp k%0d busy", k), DATA_W'(busy), DATA_W'(1));
            checkOutput($sformatf("bp k%0d in0_rdy", k), DATA_W'(in0_rdy), DATA_W'(r));
            if (r) p++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("bp end busy", DATA_W'(busy), DATA_W'(0));

        // Reset asserted in mid-packet must clear the outputs asynchronously.
        // After release, in1 must be granted first when in0 is idle.
        doReset();
        applyStimulus(1'b1, hdr(4, 'h90), 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 'h91, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 'h92, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 'h93, 1'b0, '0, 1'b1);
        #1;
        checkOutput("rst pre busy", DATA_W'(busy), DATA_W'(1));
`ifdef NOC_MEM_ARB_PERF_EN
        checkOutput("rst pre pkt_cnt0", DATA_W'(pkt_cnt0), DATA_W'(1));
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_val", DATA_W'(out_val), DATA_W'(0));
        checkOutput("rst busy", DATA_W'(busy), DATA_W'(0));
        checkOutput("rst in0_rdy", DATA_W'(in0_rdy), DATA_W'(0));
`ifdef NOC_MEM_ARB_PERF_EN
        checkOutput("rst pkt_cnt0", DATA_W'(pkt_cnt0), DATA_W'(0));
        checkOutput("rst pkt_cnt1", DATA_W'(pkt_cnt1), DATA_W'(0));
`endif
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, hdr(0, 'hA0), 1'b1);
        @(negedge clk);
        checkOutput("post out_val", DATA_W'(out_val), DATA_W'(1));
        checkOutput("post out_dat", out_dat, hdr(0, 'hA0));
        checkOutput("post in1_rdy", DATA_W'(in1_rdy), DATA_W'(1));
        checkOutput("post gnt_id", DATA_W'(gnt_id), DATA_W'(0));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("post2 gnt_id", DATA_W'(gnt_id), DATA_W'(1));
        checkOutput("post2 busy", DATA_W'(busy), DATA_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
